axi_b_resp_fifo: RTL and testbench
==================================

// Module: axi_b_resp_fifo
// PURPOSE
//  Parametrised AXI write-response (B channel) buffer between a slave-side B source and master-side B sink.
//  Replaces the single-entry B buffer with a DEPTH-entry FIFO, optional same-cycle fall-through, occupancy
//  output and error-response monitoring (sticky flag + saturating counter). Sits in the chipset AXI bridge path.
// PARAMETERS
//  ID_WIDTH      16  AXI ID width (>=1)
//  USER_WIDTH    10  AXI B user width (>=1)
//  DEPTH          4  FIFO entries; power of two, >=2
//  FALL_THROUGH   0  1: empty FIFO passes input to output in the same cycle; 0: 1-cycle registered latency
//  ERR_CNT_W      8  width of error counter
// PORTS
//  clk_i          in   1                 clock, all state on rising edge
//  rst_i          in   1                 asynchronous reset, active-high
//  test_en_i      in   1                 test mode; no functional effect
//  slave_valid_i  in   1                 B response valid from slave side
//  slave_resp_i   in   2                 BRESP (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR)
//  slave_id_i     in   ID_WIDTH          BID
//  slave_user_i   in   USER_WIDTH        BUSER
//  slave_ready_o  out  1                 buffer can accept
//  master_valid_o out  1                 head entry valid
//  master_resp_o  out  2                 head BRESP
//  master_id_o    out  ID_WIDTH          head BID
//  master_user_o  out  USER_WIDTH        head BUSER
//  master_ready_i in   1                 sink accepts head
//  count_o        out  $clog2(DEPTH+1)   entries held
//  err_clr_i      in   1                 clear err_sticky_o and err_cnt_o
//  err_sticky_o   out  1                 an SLVERR/DECERR was accepted since last clear
//  err_cnt_o      out  ERR_CNT_W         accepted SLVERR/DECERR count, saturating
// BEHAVIOUR
//  Reset (async, rst_i=1): wr/rd pointers, count_o, err_* -> 0; slave_ready_o=0; master_valid_o=0;
//   master_resp_o/id/user=0. Storage array not reset. Reset mid-transfer discards all entries.
//  init_q flop: 0 in reset, 1 from first rising edge after rst_i deasserts; slave_ready_o = init_q & (count_o!=DEPTH).
//  Push = slave_valid_i & slave_ready_o; pop = master_valid_o & master_ready_i. Valid never depends on ready.
//  FALL_THROUGH=0: master_valid_o = (count_o!=0); head from mem[rd_ptr]; push at edge N -> valid after edge N.
//  FALL_THROUGH=1: count_o==0 & slave_valid_i & init_q -> master_valid_o=1, outputs = slave_* same cycle;
//   if pop same cycle, entry bypasses (no write, count stays 0); else it is written normally.
//  Outputs masked: master_resp/id/user = 0 whenever master_valid_o=0.
//  Full (count_o==DEPTH): slave_ready_o=0 even if pop same cycle (no push-on-full).
//  Push & pop same cycle, non-empty: count_o unchanged, both pointers advance.
//  Pointers $clog2(DEPTH) bits, wrap DEPTH-1 -> 0; count_o exact 0..DEPTH. Order strictly FIFO.
//  Error monitor on push (incl. bypass): resp[1]==1 -> err_sticky_o<=1, err_cnt_o+=1, holds at all-ones.
//  err_clr_i wins over same-cycle increment: result 0, sticky 0.
// STRUCTURE
//  Package axi_resp_pkg: BRESP localparams RESP_OKAY/EXOKAY/SLVERR/DECERR; typedef of {resp,id,user} entry width.
//  One sub-module: axi_b_fifo_mem (DEPTH x (2+ID_WIDTH+USER_WIDTH) storage, write port + async read at rd_ptr).
//  Pointer/count/ready/error logic in top; no FSM beyond init_q.
// TESTING
//  1 Reset release, slave_valid_i=1: slave_ready_o=0 until first edge after release, then 1.
//  2 FT=0, push 4 (id 1..4, resp 00) with master_ready_i=0 -> count_o=4, slave_ready_o=0; drain -> ids 1,2,3,4.
//  3 FT=1 empty, slave_valid_i=1 id=0x5, master_ready_i=1 -> master_valid_o=1 same cycle, count_o stays 0.
//  4 Full FIFO, slave_valid_i=1 & master_ready_i=1 -> one pop only, count_o=3, next cycle accepts push.
//  5 Push resps 10,11,00 -> err_cnt_o=2, err_sticky_o=1; err_clr_i with push of 10 same cycle -> 0, 0.
//  6 ERR_CNT_W=2, push 5 SLVERR -> err_cnt_o=3; assert rst_i mid-stream -> count_o=0, master_valid_o=0 at once.

Source files
------------

// File: rtl/axi_resp_pkg.sv
// Purpose: shared definitions for the AXI write-response (B channel) buffer.
//   - BRESP encodings
//   - resp_t, the BRESP field type
//   - entry_width(), the packed width of one stored {resp, id, user} entry
// Ports: none (package).
package axi_resp_pkg;

  localparam int RESP_W = 2;

  typedef logic [RESP_W-1:0] resp_t;

  localparam resp_t RESP_OKAY   = 2'b00;
  localparam resp_t RESP_EXOKAY = 2'b01;
  localparam resp_t RESP_SLVERR = 2'b10;
  localparam resp_t RESP_DECERR = 2'b11;

  // Entries are packed MSB-first as {resp, id, user}.
  function automatic int entry_width(input int id_w, input int user_w);
    return RESP_W + id_w + user_w;
  endfunction

endpackage

// File: rtl/axi_b_fifo_mem.sv
// Purpose: DEPTH x WIDTH storage for the B-response FIFO. The write port is
//   synchronous and the read port is asynchronous. Storage is deliberately not
//   reset: a location is only ever read after it has been written.
// Ports:
//   clk_i      in   clock
//   wr_en_i    in   write strobe
//   wr_ptr_i   in   write address
//   wr_data_i  in   write data
//   rd_ptr_i   in   read address
//   rd_data_o  out  read data (combinational)
module axi_b_fifo_mem #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 28,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk_i,
  input  logic             wr_en_i,
  input  logic [PTR_W-1:0] wr_ptr_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic [PTR_W-1:0] rd_ptr_i,
  output logic [WIDTH-1:0] rd_data_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem_q[wr_ptr_i] <= wr_data_i;
    end
  end

  assign rd_data_o = mem_q[rd_ptr_i];

endmodule

// File: rtl/axi_b_resp_fifo.sv
// Purpose: DEPTH-entry AXI B-channel buffer between a slave-side B source and a
//   master-side B sink. It supports an optional same-cycle fall-through when
//   empty, reports occupancy, and monitors SLVERR/DECERR responses with a
//   sticky flag and a saturating counter.
// Ports:
//   clk_i, rst_i                clock and asynchronous active-high reset
//   test_en_i                   test mode (no functional effect)
//   slave_valid_i/resp/id/user  incoming B response
//   slave_ready_o               buffer can accept
//   master_valid_o/resp/id/user head of buffer (fields zero when not valid)
//   master_ready_i              sink accepts head
//   count_o                     entries held
//   err_clr_i                   clear the error monitor
//   err_sticky_o, err_cnt_o     error monitor state
module axi_b_resp_fifo
  import axi_resp_pkg::*;
#(
  parameter int ID_WIDTH     = 16,
  parameter int USER_WIDTH   = 10,
  parameter int DEPTH        = 4,
  parameter int FALL_THROUGH = 0,
  parameter int ERR_CNT_W    = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       test_en_i,
  input  logic                       slave_valid_i,
  input  logic [1:0]                 slave_resp_i,
  input  logic [ID_WIDTH-1:0]        slave_id_i,
  input  logic [USER_WIDTH-1:0]      slave_user_i,
  output logic                       slave_ready_o,
  output logic                       master_valid_o,
  output logic [1:0]                 master_resp_o,
  output logic [ID_WIDTH-1:0]        master_id_o,
  output logic [USER_WIDTH-1:0]      master_user_o,
  input  logic                       master_ready_i,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  input  logic                       err_clr_i,
  output logic                       err_sticky_o,
  output logic [ERR_CNT_W-1:0]       err_cnt_o
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = $clog2(DEPTH+1);
  localparam int ENTRY_W = entry_width(ID_WIDTH, USER_WIDTH);
  localparam bit FT_EN   = (FALL_THROUGH != 0);

  logic               init_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               err_sticky_q;
  logic [ERR_CNT_W-1:0] err_cnt_q;

  logic               empty;
  logic               full;
  logic               bypass_valid;
  logic               push;
  logic               pop;
  logic               wr_en;
  logic               rd_adv;
  logic [ENTRY_W-1:0] wr_data;
  logic [ENTRY_W-1:0] rd_data;
  logic [ENTRY_W-1:0] head_data;
  logic               unused_test_en;

  assign unused_test_en = test_en_i;

  assign empty = (count_q == '0);
  assign full  = (count_q == CNT_W'(DEPTH));

  // The buffer refuses input until the first edge after reset. It also refuses
  // input whenever it is full, even if a pop happens in the same cycle.
  assign slave_ready_o = init_q & ~full;

  // With fall-through enabled, an empty buffer presents the incoming response
  // at its output directly.
  assign bypass_valid   = FT_EN & empty & slave_valid_i & init_q;
  assign master_valid_o = ~empty | bypass_valid;

  assign push = slave_valid_i & slave_ready_o;
  assign pop  = master_valid_o & master_ready_i;

  // A bypassed entry that is consumed in the same cycle never touches storage.
  // The read pointer only moves when a stored entry leaves the buffer.
  assign wr_en  = push & ~(bypass_valid & master_ready_i);
  assign rd_adv = pop & ~empty;

  assign wr_data   = {slave_resp_i, slave_id_i, slave_user_i};
  assign head_data = empty ? wr_data : rd_data;

  assign master_resp_o = master_valid_o ? head_data[ENTRY_W-1 -: 2] : '0;
  assign master_id_o   = master_valid_o ? head_data[USER_WIDTH +: ID_WIDTH] : '0;
  assign master_user_o = master_valid_o ? head_data[USER_WIDTH-1:0] : '0;

  assign count_o      = count_q;
  assign err_sticky_o = err_sticky_q;
  assign err_cnt_o    = err_cnt_q;

  axi_b_fifo_mem #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W),
    .PTR_W (PTR_W)
  ) u_mem (
    .clk_i     (clk_i),
    .wr_en_i   (wr_en),
    .wr_ptr_i  (wr_ptr_q),
    .wr_data_i (wr_data),
    .rd_ptr_i  (rd_ptr_q),
    .rd_data_o (rd_data)
  );

  // Pointers wrap naturally because DEPTH is a power of two. When a push and a
  // pop of stored entries happen in the same cycle, the count is unchanged.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      init_q   <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      init_q <= 1'b1;
      if (wr_en) begin
        wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      end
      if (rd_adv) begin
        rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      end
      if (wr_en && !rd_adv) begin
        count_q <= count_q + CNT_W'(1);
      end else if (!wr_en && rd_adv) begin
        count_q <= count_q - CNT_W'(1);
      end
    end
  end

  // Error monitor: every accepted SLVERR/DECERR (resp[1] set) counts,
  // including bypassed entries. A clear overrides an increment in the same cycle.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else if (err_clr_i) begin
      err_sticky_q <= 1'b0;
      err_cnt_q    <= '0;
    end else if (push && slave_resp_i[1]) begin
      err_sticky_q <= 1'b1;
      if (err_cnt_q != '1) begin
        err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
      end
    end
  end

endmodule

// File: tb/tb_axi_b_resp_fifo.sv
// Purpose: self-checking bench for axi_b_resp_fifo. Three instances share one
//   stimulus stream:
//     dut_r  registered (FALL_THROUGH=0)
//     dut_f  fall-through (FALL_THROUGH=1)
//     dut_s  registered with a 2-bit error counter
//   A scoreboard queue holds the responses the registered instances should
//   return, in order.
module tb_axi_b_resp_fifo;

  localparam int ID_W   = 16;
  localparam int USER_W = 10;
  localparam int DEPTH  = 4;
  localparam int CNT_W  = $clog2(DEPTH+1);

  typedef struct packed {
    logic [1:0]        resp;
    logic [ID_W-1:0]   id;
    logic [USER_W-1:0] user;
  } entry_t;

  logic              clk;
  logic              rst;
  logic              test_en;
  logic              s_valid;
  logic [1:0]        s_resp;
  logic [ID_W-1:0]   s_id;
  logic [USER_W-1:0] s_user;
  logic              m_ready;
  logic              err_clr;

  logic              r_ready, r_valid, r_sticky;
  logic [1:0]        r_resp;
  logic [ID_W-1:0]   r_id;
  logic [USER_W-1:0] r_user;
  logic [CNT_W-1:0]  r_count;
  logic [7:0]        r_err_cnt;

  logic              f_ready, f_valid, f_sticky;
  logic [1:0]        f_resp;
  logic [ID_W-1:0]   f_id;
  logic [USER_W-1:0] f_user;
  logic [CNT_W-1:0]  f_count;
  logic [7:0]        f_err_cnt;

  logic              s_ready_o, s_valid_o, s_sticky;
  logic [1:0]        s_resp_o;
  logic [ID_W-1:0]   s_id_o;
  logic [USER_W-1:0] s_user_o;
  logic [CNT_W-1:0]  s_count;
  logic [1:0]        s_err_cnt;

  entry_t sb[$];
  int     checks;
  int     failures;

  axi_b_resp_fifo #(.ID_WIDTH(ID_W), .USER_WIDTH(USER_W), .DEPTH(DEPTH),
                    .FALL_THROUGH(0), .ERR_CNT_W(8)) dut_r (
    .clk_i(clk), .rst_i(rst), .test_en_i(test_en),
    .slave_valid_i(s_valid), .slave_resp_i(s_resp), .slave_id_i(s_id),
    .slave_user_i(s_user), .slave_ready_o(r_ready),
    .master_valid_o(r_valid), .master_resp_o(r_resp), .master_id_o(r_id),
    .master_user_o(r_user), .master_ready_i(m_ready), .count_o(r_count),
    .err_clr_i(err_clr), .err_sticky_o(r_sticky), .err_cnt_o(r_err_cnt));

  axi_b_resp_fifo #(.ID_WIDTH(ID_W), .USER_WIDTH(USER_W), .DEPTH(DEPTH),
                    .FALL_THROUGH(1), .ERR_CNT_W(8)) dut_f (
    .clk_i(clk), .rst_i(rst), .test_en_i(test_en),
    .slave_valid_i(s_valid), .slave_resp_i(s_resp), .slave_id_i(s_id),
    .slave_user_i(s_user), .slave_ready_o(f_ready),
    .master_valid_o(f_valid), .master_resp_o(f_resp), .master_id_o(f_id),
    .master_user_o(f_user), .master_ready_i(m_ready), .count_o(f_count),
    .err_clr_i(err_clr), .err_sticky_o(f_sticky), .err_cnt_o(f_err_cnt));

  axi_b_resp_fifo #(.ID_WIDTH(ID_W), .USER_WIDTH(USER_W), .DEPTH(DEPTH),
                    .FALL_THROUGH(0), .ERR_CNT_W(2)) dut_s (
    .clk_i(clk), .rst_i(rst), .test_en_i(test_en),
    .slave_valid_i(s_valid), .slave_resp_i(s_resp), .slave_id_i(s_id),
    .slave_user_i(s_user), .slave_ready_o(s_ready_o),
    .master_valid_o(s_valid_o), .master_resp_o(s_resp_o), .master_id_o(s_id_o),
    .master_user_o(s_user_o), .master_ready_i(m_ready), .count_o(s_count),
    .err_clr_i(err_clr), .err_sticky_o(s_sticky), .err_cnt_o(s_err_cnt));

  // Free-running clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [USER_W-1:0] user_of(input int id);
    return USER_W'(id * 3 + 1);
  endfunction

  // Compare one observed value against its expected value; count the check,
  // and count and report a failure.
  task automatic checkOutput(input string tag, input logic [31:0] obs,
                             input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle's inputs. When the bench knows this transfer will be
  // accepted by the registered instances, push it onto the scoreboard.
  task automatic applyStimulus(input bit v, input logic [1:0] resp, input int id,
                               input bit rdy, input bit clr, input bit accept);
    entry_t e;
    s_valid = v;
    s_resp  = resp;
    s_id    = ID_W'(id);
    s_user  = user_of(id);
    m_ready = rdy;
    err_clr = clr;
    if (accept) begin
      e.resp = resp;
      e.id   = ID_W'(id);
      e.user = user_of(id);
      sb.push_back(e);
    end
    #1;
  endtask

  // If the registered instances hand over their head this cycle, compare it
  // with the oldest scoreboard entry. Then move on to just after the next edge.
  task automatic advanceCycle();
    entry_t e;
    if (m_ready && r_valid) begin
      checkOutput("sb_not_empty", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        checkOutput("r_head_resp", 32'(r_resp), 32'(e.resp));
        checkOutput("r_head_id", 32'(r_id), 32'(e.id));
        checkOutput("r_head_user", 32'(r_user), 32'(e.user));
        checkOutput("s_head_id", 32'(s_id_o), 32'(e.id));
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_en  = 1'b0;
    s_valid  = 1'b1;
    s_resp   = 2'b00;
    s_id     = '0;
    s_user   = '0;
    m_ready  = 1'b0;
    err_clr  = 1'b0;

    // Reset state, then release with slave_valid held high.
    @(posedge clk);
    #1;
    checkOutput("rst_count", 32'(r_count), 32'd0);
    checkOutput("rst_valid", 32'(r_valid), 32'd0);
    checkOutput("rst_ready", 32'(r_ready), 32'd0);
    checkOutput("rst_id", 32'(r_id), 32'd0);
    checkOutput("rst_err_cnt", 32'(r_err_cnt), 32'd0);
    checkOutput("rst_sticky", 32'(r_sticky), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("init_ready_low", 32'(r_ready), 32'd0);
    checkOutput("init_ft_valid_low", 32'(f_valid), 32'd0);
    @(posedge clk);
    #1;
    checkOutput("init_ready_high", 32'(r_ready), 32'd1);
    checkOutput("init_count", 32'(r_count), 32'd0);

    // Fill with ids 1..4 while the sink stalls, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      applyStimulus(1'b1, 2'b00, i, 1'b0, 1'b0, 1'b1);
      advanceCycle();
    end
    applyStimulus(1'b1, 2'b00, 5, 1'b0, 1'b0, 1'b0);
    checkOutput("full_count", 32'(r_count), 32'd4);
    checkOutput("full_ready", 32'(r_ready), 32'd0);
    checkOutput("full_head_id", 32'(r_id), 32'd1);
    checkOutput("ft_full_count", 32'(f_count), 32'd4);
    advanceCycle();
    checkOutput("full_hold_count", 32'(r_count), 32'd4);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 2'b00, 0, 1'b1, 1'b0, 1'b0);
      advanceCycle();
    end
    checkOutput("drain_count", 32'(r_count), 32'd0);
    checkOutput("drain_valid", 32'(r_valid), 32'd0);
    checkOutput("drain_id_masked", 32'(r_id), 32'd0);

    // Fall-through: an empty buffer passes the response straight to the sink.
    applyStimulus(1'b1, 2'b00, 5, 1'b1, 1'b0, 1'b1);
    checkOutput("ft_valid", 32'(f_valid), 32'd1);
    checkOutput("ft_id", 32'(f_id), 32'd5);
    checkOutput("ft_user", 32'(f_user), 32'(user_of(5)));
    checkOutput("reg_valid_lat", 32'(r_valid), 32'd0);
    advanceCycle();
    checkOutput("ft_bypass_count", 32'(f_count), 32'd0);
    checkOutput("reg_count_one", 32'(r_count), 32'd1);
    checkOutput("reg_valid_after", 32'(r_valid), 32'd1);
    applyStimulus(1'b0, 2'b00, 0, 1'b1, 1'b0, 1'b0);
    advanceCycle();
    checkOutput("ft_idle_valid", 32'(f_valid), 32'd0);
    checkOutput("ft_idle_id", 32'(f_id), 32'd0);

    // Full buffer with valid and ready both high: only one pop, no push.
    for (int i = 6; i <= 9; i++) begin
      applyStimulus(1'b1, 2'b00, i, 1'b0, 1'b0, 1'b1);
      advanceCycle();
    end
    applyStimulus(1'b1, 2'b00, 10, 1'b1, 1'b0, 1'b0);
    checkOutput("full_pop_ready", 32'(r_ready), 32'd0);
    checkOutput("ft_full_pop_ready", 32'(f_ready), 32'd0);
    advanceCycle();
    checkOutput("one_pop_count", 32'(r_count), 32'd3);
    checkOutput("ft_one_pop_count", 32'(f_count), 32'd3);
    checkOutput("reopen_ready", 32'(r_ready), 32'd1);
    applyStimulus(1'b1, 2'b00, 10, 1'b1, 1'b0, 1'b1);
    advanceCycle();
    checkOutput("push_pop_count", 32'(r_count), 32'd3);
    checkOutput("push_pop_head", 32'(r_id), 32'd8);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 2'b00, 0, 1'b1, 1'b0, 1'b0);
      advanceCycle();
    end
    checkOutput("drain2_count", 32'(r_count), 32'd0);

    // Error monitor: two error responses counted, then a clear wins over an
    // error pushed in the same cycle.
    applyStimulus(1'b1, 2'b10, 11, 1'b1, 1'b0, 1'b1);
    advanceCycle();
    applyStimulus(1'b1, 2'b11, 12, 1'b1, 1'b0, 1'b1);
    advanceCycle();
    applyStimulus(1'b1, 2'b00, 13, 1'b1, 1'b0, 1'b1);
    advanceCycle();
    checkOutput("err_cnt_two", 32'(r_err_cnt), 32'd2);
    checkOutput("err_sticky_set", 32'(r_sticky), 32'd1);
    checkOutput("ft_err_cnt_two", 32'(f_err_cnt), 32'd2);
    checkOutput("sat_err_cnt_two", 32'(s_err_cnt), 32'd2);
    applyStimulus(1'b1, 2'b10, 14, 1'b1, 1'b1, 1'b1);
    advanceCycle();
    checkOutput("err_clr_cnt", 32'(r_err_cnt), 32'd0);
    checkOutput("err_clr_sticky", 32'(r_sticky), 32'd0);
    checkOutput("ft_err_clr_cnt", 32'(f_err_cnt), 32'd0);
    applyStimulus(1'b0, 2'b00, 0, 1'b1, 1'b0, 1'b0);
    advanceCycle();
    checkOutput("sb_drained", 32'(sb.size()), 32'd0);
    checkOutput("err_drain_count", 32'(r_count), 32'd0);

    // Saturation of the narrow counter, then reset in the middle of traffic.
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 2'b10, 20 + i, 1'b1, 1'b0, 1'b1);
      advanceCycle();
    end
    checkOutput("sat_err_cnt", 32'(s_err_cnt), 32'd3);
    checkOutput("sat_sticky", 32'(s_sticky), 32'd1);
    checkOutput("wide_err_cnt", 32'(r_err_cnt), 32'd5);
    applyStimulus(1'b1, 2'b11, 25, 1'b0, 1'b0, 1'b1);
    advanceCycle();
    checkOutput("sat_err_hold", 32'(s_err_cnt), 32'd3);
    checkOutput("wide_err_cnt6", 32'(r_err_cnt), 32'd6);
    checkOutput("pre_rst_count", 32'(r_count), 32'd2);
    rst = 1'b1;
    #1;
    checkOutput("async_rst_count", 32'(r_count), 32'd0);
    checkOutput("async_rst_valid", 32'(r_valid), 32'd0);
    checkOutput("async_rst_ready", 32'(r_ready), 32'd0);
    checkOutput("async_rst_ft_valid", 32'(f_valid), 32'd0);
    checkOutput("async_rst_ft_count", 32'(f_count), 32'd0);
    checkOutput("async_rst_err", 32'(s_err_cnt), 32'd0);
    sb.delete();
    advanceCycle();
    rst = 1'b0;
    advanceCycle();
    checkOutput("post_rst_ready", 32'(r_ready), 32'd1);
    checkOutput("post_rst_count", 32'(r_count), 32'd0);
    applyStimulus(1'b0, 2'b00, 0, 1'b0, 1'b0, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
